decade_timer_ctrl: RTL and testbench

Controller that sequences a chain of cascaded mod-10 (BCD) digit counters as a start/pause/clear timer with a programmable terminal count. It gates counting with an external tick strobe, compares the BCD value against a target, and raises a one-cycle done pulse. It either halts at the target or auto-reloads. It sits between a prescaler (tick source) and display/interrupt logic.

---
 rtl/decade_timer_pkg.sv | 19 +
 rtl/decade_digit.sv | 30 +++
 rtl/decade_timer_ctrl.sv | 114 +++++++++++
 tb/tb_decade_timer_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/decade_timer_pkg.sv
// rtl/decade_timer_pkg.sv - shared state encoding, BCD constants and digit saturation helper for the decade timer
package decade_timer_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Clamp a nibble to a legal BCD digit; non-decimal codes become 9.
  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/decade_digit.sv
// rtl/decade_digit.sv - one mod-10 BCD digit with clear, saturating load and count enable
module decade_digit
  import decade_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             en,
  output logic [BCD_W-1:0] digit,
  output logic             carry
);

  // Digit register: clear beats load beats increment; 9 rolls over to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (load) begin
      digit <= bcd_sat(load_val);
    end else if (en) begin
      digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
    end
  end

  assign carry = (digit == BCD_MAX);

endmodule

// File: rtl/decade_timer_ctrl.sv
// rtl/decade_timer_ctrl.sv - start/pause/clear BCD timer with terminal count; DECADE_TIMER_PRESET_EN adds load/load_val preset
module decade_timer_ctrl
  import decade_timer_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        clear,
  input  logic                        tick,
  input  logic [BCD_W*NUM_DIGITS-1:0] target,
`ifdef DECADE_TIMER_PRESET_EN
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
`endif
  output logic [BCD_W*NUM_DIGITS-1:0] bcd,
  output logic                        running,
  output logic                        done,
  output logic                        cout
);

  state_t state, state_nxt;

  logic                        load_q;
  logic [BCD_W*NUM_DIGITS-1:0] load_bus;
  logic                        pause_q;
  logic                        start_q;
  logic                        cnt_tick;
  logic                        term;
  logic                        inc;
  logic                        digit_clr;
  logic [NUM_DIGITS-1:0]       carry;
  logic [NUM_DIGITS:0]         en_chain;

`ifdef DECADE_TIMER_PRESET_EN
  // A preset is only honoured while the count is not advancing.
  assign load_q   = load & (state != ST_RUN);
  assign load_bus = load_val;
`else
  assign load_q   = 1'b0;
  assign load_bus = '0;
`endif

  // Command priority: clear > load > pause > start.
  assign pause_q  = pause & ~clear & ~load_q;
  assign start_q  = start & ~clear & ~load_q & ~pause;

  // A tick counts only in RUN when no higher command claims the cycle.
  assign cnt_tick = (state == ST_RUN) & tick & ~pause & ~clear;
  assign term     = cnt_tick & (bcd == target);
  assign inc      = cnt_tick & ~term;

  assign digit_clr = clear | (term & AUTO_RELOAD) | ((state == ST_DONE) & start_q);

  assign en_chain[0] = inc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign en_chain[gi+1] = en_chain[gi] & carry[gi];

      decade_digit u_digit (
        .clk      (clk),
        .rst      (rst),
        .clr      (digit_clr),
        .load     (load_q),
        .load_val (load_bus[gi*BCD_W +: BCD_W]),
        .en       (en_chain[gi]),
        .digit    (bcd[gi*BCD_W +: BCD_W]),
        .carry    (carry[gi])
      );
    end
  endgenerate

  // Next-state selection for the run/pause/done sequencing.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else if (load_q) begin
      state_nxt = ST_PAUSE;
    end else begin
      unique case (state)
        ST_IDLE:  if (start_q) state_nxt = ST_RUN;
        ST_RUN: begin
          if (pause_q)                  state_nxt = ST_PAUSE;
          else if (term && !AUTO_RELOAD) state_nxt = ST_DONE;
        end
        ST_PAUSE: if (start_q) state_nxt = ST_RUN;
        ST_DONE:  if (start_q) state_nxt = ST_RUN;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and registered status pulses; running tracks the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      done    <= 1'b0;
      cout    <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      done    <= term;
      cout    <= en_chain[NUM_DIGITS];
    end
  end

endmodule

// File: tb/tb_decade_timer_ctrl.sv
// tb/tb_decade_timer_ctrl.sv - scoreboard bench for decade_timer_ctrl, halting and auto-reload instances side by side
module tb_decade_timer_ctrl;

  localparam int ND = 2;
  localparam int W  = 4 * ND;
  localparam int MAXV = 99;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  typedef struct packed {
    logic [W-1:0] bcd;
    logic         running;
    logic         done;
    logic         cout;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst, start, pause, clear, tick, load;
  logic [W-1:0] target, load_val;
  logic [W-1:0] bcd0, bcd1;
  logic         running0, running1, done0, done1, cout0, cout1;

  obs_t sb0[$];
  obs_t sb1[$];

  int m_cnt [2];
  int m_st  [2];
  bit m_done[2];
  bit m_cout[2];

  int n_checks = 0;
  int n_fail   = 0;
  int n_done0 = 0, n_done1 = 0, n_cout0 = 0, n_cout1 = 0;

  always #5 clk = ~clk;

  decade_timer_ctrl #(.NUM_DIGITS(ND), .AUTO_RELOAD(1'b0)) u_dut_halt (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .tick(tick), .target(target),
`ifdef DECADE_TIMER_PRESET_EN
    .load(load), .load_val(load_val),
`endif
    .bcd(bcd0), .running(running0), .done(done0), .cout(cout0)
  );

  decade_timer_ctrl #(.NUM_DIGITS(ND), .AUTO_RELOAD(1'b1)) u_dut_reload (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .tick(tick), .target(target),
`ifdef DECADE_TIMER_PRESET_EN
    .load(load), .load_val(load_val),
`endif
    .bcd(bcd1), .running(running1), .done(done1), .cout(cout1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // BCD to integer; -1 for a non-decimal digit unless saturating.
  function automatic int bcd2int(input logic [W-1:0] v, input bit sat);
    int n = 0;
    int p = 1;
    for (int i = 0; i < ND; i++) begin
      int d = int'(v[i*4 +: 4]);
      if (d > 9) begin
        if (sat) d = 9;
        else return -1;
      end
      n += d * p;
      p *= 10;
    end
    return n;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] v;
    int r = n;
    for (int i = 0; i < ND; i++) begin
      v[i*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return v;
  endfunction

  // Advance the behavioural model of instance k by one clock.
  task automatic model_step(input int k, input bit s, input bit p, input bit c, input bit t, input bit l);
    int tg = bcd2int(target, 1'b0);
    m_done[k] = 1'b0;
    m_cout[k] = 1'b0;
    if (rst) begin
      m_cnt[k] = 0;
      m_st[k]  = S_IDLE;
    end else if (c) begin
      m_cnt[k] = 0;
      m_st[k]  = S_IDLE;
    end else if (l && m_st[k] != S_RUN) begin
      m_cnt[k] = bcd2int(load_val, 1'b1);
      m_st[k]  = S_PAUSE;
    end else if (m_st[k] == S_RUN) begin
      if (p) begin
        m_st[k] = S_PAUSE;
      end else if (t) begin
        if (m_cnt[k] == tg) begin
          m_done[k] = 1'b1;
          if (k == 1) m_cnt[k] = 0;
          else        m_st[k]  = S_DONE;
        end else if (m_cnt[k] == MAXV) begin
          m_cnt[k]  = 0;
          m_cout[k] = 1'b1;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end else if (s && !p) begin
      if (m_st[k] == S_DONE) m_cnt[k] = 0;
      m_st[k] = S_RUN;
    end
  endtask

  // One clock: drive, push expectations, clock, pop and compare.
  task automatic cyc(input bit s, input bit p, input bit c, input bit t, input bit l);
    obs_t e0, e1;
    start = s; pause = p; clear = c; tick = t; load = l;
    for (int k = 0; k < 2; k++) model_step(k, s, p, c, t, l);
    sb0.push_back('{int2bcd(m_cnt[0]), m_st[0] == S_RUN, m_done[0], m_cout[0]});
    sb1.push_back('{int2bcd(m_cnt[1]), m_st[1] == S_RUN, m_done[1], m_cout[1]});
    @(posedge clk);
    #1;
    e0 = sb0.pop_front();
    e1 = sb1.pop_front();
    check_eq("halt_bcd",     32'(bcd0),     32'(e0.bcd));
    check_eq("halt_running", 32'(running0), 32'(e0.running));
    check_eq("halt_done",    32'(done0),    32'(e0.done));
    check_eq("halt_cout",    32'(cout0),    32'(e0.cout));
    check_eq("rel_bcd",      32'(bcd1),     32'(e1.bcd));
    check_eq("rel_running",  32'(running1), 32'(e1.running));
    check_eq("rel_done",     32'(done1),    32'(e1.done));
    check_eq("rel_cout",     32'(cout1),    32'(e1.cout));
    if (done0) n_done0++;
    if (done1) n_done1++;
    if (cout0) n_cout0++;
    if (cout1) n_cout1++;
  endtask

  task automatic clear_counts();
    n_done0 = 0; n_done1 = 0; n_cout0 = 0; n_cout1 = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; tick = 1'b0; load = 1'b0;
    target = 8'h12; load_val = 8'h00;
    m_cnt = '{0, 0}; m_st = '{S_IDLE, S_IDLE}; m_done = '{0, 0}; m_cout = '{0, 0};

    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check_eq("reset_bcd", 32'(bcd0), 32'h0);
    rst = 1'b0;

    // count to 12 and halt
    clear_counts();
    cyc(1, 0, 0, 0, 0);
    repeat (15) cyc(0, 0, 0, 1, 0);
    check_eq("t12_done_pulses", 32'(n_done0), 32'd1);
    check_eq("t12_hold_bcd",    32'(bcd0),    32'h12);
    check_eq("t12_not_running", 32'(running0), 32'd0);

    // pause at 05 with tick, hold, resume
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    repeat (20) cyc(0, 0, 0, 1, 0);
    check_eq("pause_hold_bcd", 32'(bcd0), 32'h05);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check_eq("resume_bcd", 32'(bcd0), 32'h06);

    // wrap with an unreachable target
    target = 8'hFF;
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    clear_counts();
    repeat (100) cyc(0, 0, 0, 1, 0);
    check_eq("wrap_cout_pulses", 32'(n_cout0), 32'd1);
    check_eq("wrap_done_pulses", 32'(n_done0), 32'd0);
    check_eq("wrap_bcd",         32'(bcd0),    32'h00);

    // auto reload at 03
    target = 8'h03;
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    clear_counts();
    repeat (12) cyc(0, 0, 0, 1, 0);
    check_eq("reload_done_pulses", 32'(n_done1), 32'd3);
    check_eq("reload_bcd",         32'(bcd1),    32'h00);

    // start + clear in PAUSE at 07
    target = 8'hFF;
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (7) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    check_eq("paused_at_07", 32'(bcd0), 32'h07);
    cyc(1, 0, 1, 0, 0);
    check_eq("startclear_bcd", 32'(bcd0), 32'h00);
    check_eq("startclear_run", 32'(running0), 32'd0);

    // reset while running at 42
    cyc(1, 0, 0, 0, 0);
    repeat (42) cyc(0, 0, 0, 1, 0);
    check_eq("pre_rst_bcd", 32'(bcd0), 32'h42);
    rst = 1'b1;
    cyc(0, 0, 0, 1, 0);
    rst = 1'b0;
    check_eq("rst_bcd",     32'(bcd0),     32'h00);
    check_eq("rst_running", 32'(running0), 32'd0);
    check_eq("rst_done",    32'(done0),    32'd0);

`ifdef DECADE_TIMER_PRESET_EN
    // preset with a non-decimal digit saturates, then wraps on the first tick
    load_val = 8'h9A;
    cyc(0, 0, 0, 0, 1);
    check_eq("load_bcd",     32'(bcd0),     32'h99);
    check_eq("load_running", 32'(running0), 32'd0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check_eq("load_wrap_bcd",  32'(bcd0),  32'h00);
    check_eq("load_wrap_cout", 32'(cout0), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
